tsu_queue_reader: RTL and testbench
===================================

// Module: tsu_queue_reader
// PURPOSE
//  Drains timestamp records from the read side of a tsu_queue instance and hands them to the host
//  bus logic as a valid/ready stream. Sits directly downstream of tsu_queue, in the q_rd_clk domain.
//  Issues single-cycle q_rd_en pulses, aligns the returned data, and buffers up to 2 records.
//  Also provides a fill-level interrupt and a flush-discard mode.
// PARAMETERS
//  RD_LAT      1   cycles from the q_rd_en cycle until q_rd_data holds that record (1..3)
//  IRQ_THRESH  1   irq asserted while q_rd_stat >= IRQ_THRESH; 0 disables irq
// PORTS
//  q_rd_clk    in   1   single clock
//  rst         in   1   asynchronous reset, active-high
//  q_rd_en     out  1   read strobe to tsu_queue, one cycle per record
//  q_rd_stat   in   8   queue entry count from tsu_queue (0 = empty)
//  q_rd_data   in   48  record returned RD_LAT cycles after q_rd_en
//  out_valid   out  1   out_data holds a record
//  out_ready   in   1   consumer accepts when out_valid && out_ready
//  out_data    out  48  head-of-buffer record
//  flush       in   1   pulse: discard buffered records and drain the queue without output
//  flush_busy  out  1   high from the cycle after flush until the drain completes
//  irq         out  1   level fill interrupt
//  rec_cnt     out  16  count of records delivered on out_*; wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: q_rd_en=0, out_valid=0, out_data=0, flush_busy=0, irq=0, rec_cnt=0. Buffer and
//    in-flight tracking are cleared. FSM goes to IDLE. Reset during an in-flight read drops that record.
//  - FSM IDLE: if flush is high, go to FLUSH. Otherwise, if q_rd_stat!=0 and buffered+in_flight < 2,
//    pulse q_rd_en for 1 cycle and go to WAIT.
//  - WAIT: hold for exactly RD_LAT cycles. In the last cycle, capture q_rd_data. In normal mode, push it
//    into the buffer. In flush mode, discard it. Then spend 1 SETTLE cycle (q_rd_stat may lag) and
//    return to IDLE or FLUSH.
//  - FLUSH: pulse q_rd_en and go to WAIT while q_rd_stat!=0. If q_rd_stat==0 after SETTLE, clear
//    flush_busy and go to IDLE.
//  - Only one read is ever outstanding, so the minimum read-to-read spacing is RD_LAT+2 cycles.
//  - Buffer: 2-entry FIFO. out_data/out_valid come from the head register, with no combinational
//    path from out_ready to q_rd_en.
//    Push and pop in the same cycle is legal, and the occupancy stays the same.
//    A record pushed into an empty buffer shows out_valid in the next cycle.
//  - Flush in IDLE: clears the buffer and out_valid in the next cycle. Flush during WAIT: the
//    in-flight record is discarded. Flush while already flush_busy is ignored.
//    A handshake in the same cycle as flush still completes and still counts in rec_cnt.
//  - irq: registered, so it lags q_rd_stat by 1 cycle. It is forced to 0 while flush_busy.
//  - rec_cnt: increments by 1 per out handshake, modulo 2^16.
//  - q_rd_data is opaque; no field interpretation is done here.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE, WAIT, SETTLE, FLUSH) and the record width
//    constant TSU_REC_W=48, which tsu_queue also uses.
//  - One sub-module: tsu_rec_fifo2 (2-entry register FIFO; push/pop/clear, occupancy count).
//  - The FSM, latency counter, irq and rec_cnt live in the top-level module.
// TESTING
//  1. Reset, then q_rd_stat=3 and out_ready=1 -> 3 q_rd_en pulses, spaced RD_LAT+2 apart; out_data
//     equals the driven records 0xA1,0xA2,0xA3 in order; rec_cnt=3; no q_rd_en once stat=0.
//  2. out_ready=0, q_rd_stat=5 -> exactly 2 reads, then q_rd_en stays low; release out_ready ->
//     the remaining 3 are read, and 5 in-order records are delivered.
//  3. Flush pulse with 2 records buffered and q_rd_stat=4 -> out_valid=0 next cycle; 4 discard reads;
//     flush_busy falls after stat=0; rec_cnt unchanged; no out_valid during the drain.
//  4. IRQ_THRESH=4: stat 3->4->3 -> irq rises 1 cycle after stat=4 and falls 1 cycle after stat=3.
//     irq stays 0 during flush.
//  5. Reset asserted in WAIT (RD_LAT=3) -> all outputs 0 immediately; the record is not delivered.
//     After release, normal reads resume.
//  6. Preload rec_cnt path with 65535 handshakes (or force the counter) -> the next handshake wraps
//     rec_cnt to 0.

Source files
------------

// File: rtl/tsu_queue_reader_pkg.sv
// Shared definitions for the tsu_queue read-side drain logic.
// TSU_REC_W must match the record width used by tsu_queue.
package tsu_queue_reader_pkg;

    localparam int TSU_REC_W = 48;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETTLE,
        ST_FLUSH
    } rd_state_e;

endpackage

// File: rtl/tsu_rec_fifo2.sv
// Two-entry register FIFO for timestamp records; the head register drives the output directly.
module tsu_rec_fifo2
    import tsu_queue_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic                 i_clear,
    input  logic [TSU_REC_W-1:0] i_data,
    output logic [TSU_REC_W-1:0] o_head,
    output logic                 o_valid,
    output logic [1:0]           o_count
);

    logic [TSU_REC_W-1:0] r_head;
    logic [TSU_REC_W-1:0] r_tail;
    logic [1:0]           r_count;
    logic                 w_pop;
    logic                 w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                // Simultaneous push/pop keeps occupancy; data shifts toward the head.
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/tsu_queue_reader.sv
// Drains tsu_queue one record at a time into a 2-deep output buffer, with flush-discard
// mode, a registered fill-level interrupt and a delivered-record counter.
module tsu_queue_reader
    import tsu_queue_reader_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int IRQ_THRESH = 1
) (
    input  logic                 q_rd_clk,
    input  logic                 rst,
    output logic                 q_rd_en,
    input  logic [7:0]           q_rd_stat,
    input  logic [TSU_REC_W-1:0] q_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TSU_REC_W-1:0] out_data,
    input  logic                 flush,
    output logic                 flush_busy,
    output logic                 irq,
    output logic [15:0]          rec_cnt
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [7:0] IRQ_TH   = 8'(IRQ_THRESH);
    localparam bit         IRQ_EN   = (IRQ_THRESH != 0);

    rd_state_e   r_state;
    rd_state_e   w_next;
    logic [1:0]  r_lat;
    logic        r_arm;
    logic        r_flush;
    logic        r_irq;
    logic [15:0] r_rec_cnt;
    logic        w_rd_en;
    logic        w_flush_done;
    logic        w_flush_acc;
    logic        w_last;
    logic        w_push;
    logic        w_hs;
    logic [1:0]  w_fifo_cnt;

    assign w_flush_acc = flush && !r_flush;
    assign w_last      = (r_state == ST_WAIT) && (r_lat == LAT_LAST);
    assign w_push      = w_last && !r_flush && !flush;
    assign w_hs        = out_valid && out_ready;

    always_comb begin
        w_next       = r_state;
        w_rd_en      = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    w_next = ST_FLUSH;
                end else if (r_arm && (q_rd_stat != 8'd0) && (w_fifo_cnt != 2'd2)) begin
                    w_rd_en = 1'b1;
                    w_next  = ST_WAIT;
                end
            end
            ST_WAIT:   if (r_lat == LAT_LAST) w_next = ST_SETTLE;
            // Extra cycle so a lagging q_rd_stat reflects the read just taken.
            ST_SETTLE: w_next = (r_flush || flush) ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: begin
                if (q_rd_stat != 8'd0) begin
                    w_rd_en = 1'b1;
                    w_next  = ST_WAIT;
                end else begin
                    w_flush_done = 1'b1;
                    w_next       = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge q_rd_clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_lat     <= 2'd0;
            r_arm     <= 1'b0;
            r_flush   <= 1'b0;
            r_irq     <= 1'b0;
            r_rec_cnt <= 16'd0;
        end else begin
            r_state <= w_next;
            r_lat   <= (r_state == ST_WAIT) ? r_lat + 2'd1 : 2'd0;
            r_arm   <= 1'b1;
            if (w_flush_acc)       r_flush <= 1'b1;
            else if (w_flush_done) r_flush <= 1'b0;
            r_irq <= IRQ_EN && (q_rd_stat >= IRQ_TH);
            if (w_hs) r_rec_cnt <= r_rec_cnt + 16'd1;
        end
    end

    tsu_rec_fifo2 u_fifo (
        .clk     (q_rd_clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (out_ready),
        .i_clear (w_flush_acc),
        .i_data  (q_rd_data),
        .o_head  (out_data),
        .o_valid (out_valid),
        .o_count (w_fifo_cnt)
    );

    // r_arm keeps the strobe low while reset is held, since IDLE issues combinationally.
    assign q_rd_en    = w_rd_en;
    assign flush_busy = r_flush;
    assign irq        = r_irq && !r_flush;
    assign rec_cnt    = r_rec_cnt;

endmodule

// File: tb/tb_tsu_queue_reader.sv
// Bench for tsu_queue_reader: behavioural queue model, scoreboard of expected records,
// and a negedge monitor that checks every handshake and read strobe.
module tb_tsu_queue_reader;
    import tsu_queue_reader_pkg::*;

    localparam int RD_LAT     = 3;
    localparam int IRQ_THRESH = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 q_rd_en;
    logic [7:0]           q_rd_stat = 8'd0;
    logic [TSU_REC_W-1:0] q_rd_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [TSU_REC_W-1:0] out_data;
    logic                 flush = 1'b0;
    logic                 flush_busy;
    logic                 irq;
    logic [15:0]          rec_cnt;

    int checks = 0;
    int errors = 0;

    // queue model controls (stimulus-owned)
    logic                 ld = 1'b0;
    int                   ld_n = 0;
    logic [TSU_REC_W-1:0] ld_base = '0;
    logic                 ld_setb = 1'b0;
    // queue model state (model-owned)
    logic [TSU_REC_W-1:0] pipe [RD_LAT];
    logic [TSU_REC_W-1:0] ptr = '0;
    int                   lvl = 0;
    logic                 en_s, ld_s, setb_s;
    int                   n_s;
    logic [TSU_REC_W-1:0] base_s;

    // scoreboard and monitor state
    logic [TSU_REC_W-1:0] exp_q [$];
    int                   en_t [$];
    logic [15:0]          m_cnt = 16'd0;
    logic                 preset_req = 1'b0;
    logic [15:0]          preset_val = 16'd0;
    int                   m_cyc = 0;
    int                   m_last = 0;
    logic                 m_have = 1'b0;
    logic [TSU_REC_W-1:0] m_exp;

    always #5 clk = ~clk;

    tsu_queue_reader #(.RD_LAT(RD_LAT), .IRQ_THRESH(IRQ_THRESH)) dut (
        .q_rd_clk   (clk),
        .rst        (rst),
        .q_rd_en    (q_rd_en),
        .q_rd_stat  (q_rd_stat),
        .q_rd_data  (q_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .flush_busy (flush_busy),
        .irq        (irq),
        .rec_cnt    (rec_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Set queue level (and optionally the next record value); expected records go to the scoreboard.
    task automatic q_load(input int n, input logic [TSU_REC_W-1:0] base, input logic setb, input logic expect_out);
        @(posedge clk); #1;
        ld = 1'b1; ld_n = n; ld_base = base; ld_setb = setb;
        if (expect_out) for (int i = 0; i < n; i++) exp_q.push_back(base + TSU_REC_W'(i));
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    task automatic wait_drained(input int bound, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // tsu_queue model: record appears RD_LAT cycles after the strobe, level drops per read.
    initial begin
        for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
        forever begin
            @(negedge clk);
            en_s = q_rd_en; ld_s = ld; n_s = ld_n; base_s = ld_base; setb_s = ld_setb;
            @(posedge clk); #1;
            for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = en_s ? ptr : '0;
            if (en_s) ptr = ptr + 1'b1;
            if (ld_s) begin
                lvl = n_s;
                if (setb_s) ptr = base_s;
            end else if (en_s && lvl != 0) begin
                lvl--;
            end
            q_rd_stat = 8'(lvl);
            q_rd_data = pipe[RD_LAT-1];
        end
    end

    // Monitor: scoreboard pops on each handshake; strobe spacing and flush-time quietness.
    initial begin
        forever begin
            @(negedge clk);
            m_cyc++;
            if (rst) begin
                m_cnt  = 16'd0;
                m_have = 1'b0;
            end else begin
                if (preset_req) m_cnt = preset_val;
                if (q_rd_en) begin
                    if (m_have) begin
                        checks++;
                        if (m_cyc - m_last < RD_LAT + 2) begin
                            errors++;
                            $display("FAIL rd_spacing actual=%0d required>=%0d", m_cyc - m_last, RD_LAT + 2);
                        end
                    end
                    m_have = 1'b1;
                    m_last = m_cyc;
                    en_t.push_back(m_cyc);
                end
                if (flush_busy) begin
                    checks++;
                    if (out_valid || irq) begin
                        errors++;
                        $display("FAIL busy_quiet actual out_valid=%0b irq=%0b required 0/0", out_valid, irq);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_record actual=%0h required none", out_data);
                    end else begin
                        m_exp = exp_q.pop_front();
                        chk("out_data", 64'(out_data), 64'(m_exp));
                    end
                    chk("rec_cnt_hs", 64'(rec_cnt), 64'(m_cnt));
                    m_cnt = m_cnt + 16'd1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int k;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_q_rd_en", 64'(q_rd_en), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_flush_busy", 64'(flush_busy), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_rec_cnt", 64'(rec_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);

        // 1: three records, streaming consumer
        out_ready = 1'b1;
        b = en_t.size();
        q_load(3, 48'hA1, 1'b1, 1'b1);
        wait_drained(60, "t1_drain");
        tick(20);
        chk("t1_reads", 64'(en_t.size() - b), 64'd3);
        if (en_t.size() - b >= 3) begin
            chk("t1_gap0", 64'(en_t[b+1] - en_t[b]), 64'(RD_LAT + 2));
            chk("t1_gap1", 64'(en_t[b+2] - en_t[b+1]), 64'(RD_LAT + 2));
        end
        chk("t1_rec_cnt", 64'(rec_cnt), 64'd3);

        // 2: back-pressure limits reads to buffer depth
        out_ready = 1'b0;
        b = en_t.size();
        q_load(5, 48'hB1, 1'b1, 1'b1);
        tick(40);
        chk("t2_reads_held", 64'(en_t.size() - b), 64'd2);
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_head", 64'(out_data), 64'hB1);
        out_ready = 1'b1;
        wait_drained(100, "t2_drain");
        tick(10);
        chk("t2_reads_all", 64'(en_t.size() - b), 64'd5);
        chk("t2_rec_cnt", 64'(rec_cnt), 64'd8);

        // 4: irq threshold with the buffer full so the level holds still
        out_ready = 1'b0;
        q_load(5, 48'hD1, 1'b1, 1'b0);
        tick(30);
        chk("t4_irq_lo", 64'(irq), 64'd0);
        q_load(4, 48'h0, 1'b0, 1'b0);
        @(negedge clk); chk("t4_irq_lag", 64'(irq), 64'd0);
        @(negedge clk); chk("t4_irq_rise", 64'(irq), 64'd1);
        q_load(3, 48'h0, 1'b0, 1'b0);
        @(negedge clk); chk("t4_irq_hold", 64'(irq), 64'd1);
        @(negedge clk); chk("t4_irq_fall", 64'(irq), 64'd0);
        q_load(4, 48'h0, 1'b0, 1'b0);
        tick(2);
        chk("t4_irq_pre_flush", 64'(irq), 64'd1);
        chk("t3_full", 64'(out_valid), 64'd1);

        // 3: flush with 2 buffered and 4 queued
        b = en_t.size();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("t3_valid_cleared", 64'(out_valid), 64'd0);
        chk("t3_busy", 64'(flush_busy), 64'd1);
        chk("t3_irq_masked", 64'(irq), 64'd0);
        tick(6);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        k = 0;
        while (flush_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t3_busy_fall", 64'(flush_busy), 64'd0);
        chk("t3_discard_reads", 64'(en_t.size() - b), 64'd4);
        chk("t3_rec_cnt", 64'(rec_cnt), 64'd8);
        tick(10);
        chk("t3_no_more_reads", 64'(en_t.size() - b), 64'd4);

        // 5: reset in the middle of an outstanding read
        out_ready = 1'b1;
        q_load(1, 48'hE1, 1'b1, 1'b0);
        k = 0;
        @(negedge clk);
        while (!q_rd_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t5_read_seen", 64'(q_rd_en), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_q_rd_en", 64'(q_rd_en), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_out_data", 64'(out_data), 64'd0);
        chk("t5_flush_busy", 64'(flush_busy), 64'd0);
        chk("t5_irq", 64'(irq), 64'd0);
        chk("t5_rec_cnt", 64'(rec_cnt), 64'd0);
        tick(3);
        rst = 1'b0;
        tick(5);
        b = en_t.size();
        q_load(2, 48'hF1, 1'b1, 1'b1);
        wait_drained(60, "t5_drain");
        tick(5);
        chk("t5_reads", 64'(en_t.size() - b), 64'd2);
        chk("t5_rec_cnt_after", 64'(rec_cnt), 64'd2);

        // 6: counter wrap
        out_ready = 1'b0;
        tick(2);
        force dut.r_rec_cnt = 16'hFFFF;
        preset_val = 16'hFFFF;
        preset_req = 1'b1;
        @(posedge clk); #1;
        release dut.r_rec_cnt;
        preset_req = 1'b0;
        @(negedge clk);
        chk("t6_preset", 64'(rec_cnt), 64'hFFFF);
        q_load(1, 48'h5A, 1'b1, 1'b1);
        out_ready = 1'b1;
        wait_drained(40, "t6_drain");
        @(negedge clk);
        chk("t6_wrap", 64'(rec_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
